// File: rtl/packet_generator.sv
// rtl/packet_generator.sv - registered packet source with handshake, sequence numbering and error injection
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   enable         in   generate packets continuously while high
//   ready          in   downstream accepts data_bus this cycle
//   payload        in   payload field, sampled on load
//   inject_f_err   in   next loaded packet gets an all-zero header
//   inject_seq_err in   next loaded packet gets a skipped sequence number
//   data_bus       out  {header, payload, seq}
//   valid          out  data_bus holds a packet
//   sent_count     out  completed transfers, wraps at 256
module packet_generator #(
  parameter int BUS_SIZE  = 16,
  parameter int WORD_SIZE = 4,
  parameter int PAY_SIZE  = BUS_SIZE - 2 * WORD_SIZE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                ready,
  input  logic [PAY_SIZE-1:0] payload,
  input  logic                inject_f_err,
  input  logic                inject_seq_err,
  output logic [BUS_SIZE-1:0] data_bus,
  output logic                valid,
  output logic [7:0]          sent_count
);

  localparam logic [WORD_SIZE-1:0] F_CODE   = {WORD_SIZE{1'b1}};
  localparam logic [WORD_SIZE-1:0] BAD_CODE = {WORD_SIZE{1'b0}};
  localparam logic [WORD_SIZE-1:0] SEQ_ONE  = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    RUN,
    RESYNC
  } state_t;

  state_t               state, state_nxt;
  logic [WORD_SIZE-1:0] next_seq, next_seq_nxt;
  logic [BUS_SIZE-1:0]  data_nxt;
  logic                 valid_nxt;
  logic [7:0]           count_nxt;
  logic                 transfer;
  logic                 load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      next_seq   <= SEQ_ONE;
      data_bus   <= '0;
      valid      <= 1'b0;
      sent_count <= 8'd0;
    end else begin
      state      <= state_nxt;
      next_seq   <= next_seq_nxt;
      data_bus   <= data_nxt;
      valid      <= valid_nxt;
      sent_count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    next_seq_nxt = next_seq;
    data_nxt     = data_bus;
    valid_nxt    = valid;
    transfer     = valid & ready;
    // A new packet may replace the held one only when the slot is empty
    // or is being emptied on this same edge.
    load         = enable & (~valid | transfer);
    count_nxt    = sent_count + {7'd0, transfer};

    if (load) begin
      valid_nxt = 1'b1;
      if (inject_f_err) begin
        data_nxt     = {BAD_CODE, payload, next_seq};
        next_seq_nxt = '0;
      end else if (inject_seq_err) begin
        data_nxt     = {F_CODE, payload, next_seq + SEQ_ONE};
        next_seq_nxt = '0;
      end else begin
        data_nxt     = {F_CODE, payload, next_seq};
        next_seq_nxt = next_seq + SEQ_ONE;
      end

      if (state == IDLE) begin
        state_nxt = FIRST;
      end else if (inject_f_err || inject_seq_err) begin
        state_nxt = RESYNC;
      end else if (state == RESYNC) begin
        state_nxt = FIRST;
      end else begin
        state_nxt = RUN;
      end
    end else if (transfer) begin
      valid_nxt = 1'b0;
      state_nxt = IDLE;
    end
  end

endmodule

// File: tb/tb_packet_generator.sv
// tb/tb_packet_generator.sv - directed self-checking bench for packet_generator
module tb_packet_generator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        ready = 1'b0;
  logic [7:0]  payload = 8'h00;
  logic        inject_f_err = 1'b0;
  logic        inject_seq_err = 1'b0;
  logic [15:0] data_bus;
  logic        valid;
  logic [7:0]  sent_count;

  int checks = 0;
  int errors = 0;

  packet_generator dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .ready          (ready),
    .payload        (payload),
    .inject_f_err   (inject_f_err),
    .inject_seq_err (inject_seq_err),
    .data_bus       (data_bus),
    .valid          (valid),
    .sent_count     (sent_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b0;
    ready = 1'b0;
    inject_f_err = 1'b0;
    inject_seq_err = 1'b0;
    payload = 8'hAB;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (data_bus !== 16'h0000) begin
      errors++; $display("FAIL reset_data got %h exp 0000", data_bus);
    end
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b exp 0", valid);
    end
    checks++;
    if (sent_count !== 8'd0) begin
      errors++; $display("FAIL reset_count got %0d exp 0", sent_count);
    end
  endtask

  task automatic test_stream_and_wrap();
    logic [15:0] exp_bus;
    do_reset();
    payload = 8'hAB;
    ready = 1'b1;
    enable = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      step();
      exp_bus = {4'hF, 8'hAB, 4'(i)};
      checks++;
      if (data_bus !== exp_bus) begin
        errors++; $display("FAIL stream_data[%0d] got %h exp %h", i, data_bus, exp_bus);
      end
      checks++;
      if (valid !== 1'b1) begin
        errors++; $display("FAIL stream_valid[%0d] got %b exp 1", i, valid);
      end
      checks++;
      if (sent_count !== 8'(i - 1)) begin
        errors++; $display("FAIL stream_count[%0d] got %0d exp %0d", i, sent_count, i - 1);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready = 1'b0;
    enable = 1'b1;
    step();
    checks++;
    if (data_bus !== 16'hFAB1 || valid !== 1'b1) begin
      errors++; $display("FAIL bp_first got %h/%b exp FAB1/1", data_bus, valid);
    end
    // Inputs churn during the stall; the held packet must not move.
    for (int i = 0; i < 3; i++) begin
      enable = i[0];
      payload = 8'h10 + 8'(i);
      inject_f_err = 1'b1;
      inject_seq_err = 1'b1;
      step();
      checks++;
      if (data_bus !== 16'hFAB1 || valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d] got %h/%b exp FAB1/1", i, data_bus, valid);
      end
      checks++;
      if (sent_count !== 8'd0) begin
        errors++; $display("FAIL bp_count[%0d] got %0d exp 0", i, sent_count);
      end
    end
    inject_f_err = 1'b0;
    inject_seq_err = 1'b0;
    payload = 8'hAB;
    enable = 1'b1;
    ready = 1'b1;
    step();
    checks++;
    if (data_bus !== 16'hFAB2) begin
      errors++; $display("FAIL bp_next got %h exp FAB2", data_bus);
    end
    checks++;
    if (sent_count !== 8'd1) begin
      errors++; $display("FAIL bp_next_count got %0d exp 1", sent_count);
    end
  endtask

  task automatic test_drain();
    do_reset();
    enable = 1'b1;
    step();
    enable = 1'b0;
    step();
    step();
    checks++;
    if (data_bus !== 16'hFAB1 || valid !== 1'b1) begin
      errors++; $display("FAIL drain_hold got %h/%b exp FAB1/1", data_bus, valid);
    end
    ready = 1'b1;
    step();
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL drain_valid got %b exp 0", valid);
    end
    checks++;
    if (sent_count !== 8'd1) begin
      errors++; $display("FAIL drain_count got %0d exp 1", sent_count);
    end
  endtask

  // Loads n good packets, arms the given injects for the next load, then
  // checks the corrupted packet and the resync packet that follows it.
  task automatic run_inject(input string name, input int n, input logic f, input logic s,
                            input logic [15:0] exp_bad);
    do_reset();
    ready = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < n; i++) step();
    inject_f_err = f;
    inject_seq_err = s;
    step();
    inject_f_err = 1'b0;
    inject_seq_err = 1'b0;
    checks++;
    if (data_bus !== exp_bad) begin
      errors++; $display("FAIL %s_bad got %h exp %h", name, data_bus, exp_bad);
    end
    step();
    checks++;
    if (data_bus !== 16'hFAB0) begin
      errors++; $display("FAIL %s_resync got %h exp FAB0", name, data_bus);
    end
    step();
    checks++;
    if (data_bus !== 16'hFAB1) begin
      errors++; $display("FAIL %s_after got %h exp FAB1", name, data_bus);
    end
    checks++;
    if (sent_count !== 8'(n + 2)) begin
      errors++; $display("FAIL %s_count got %0d exp %0d", name, sent_count, n + 2);
    end
  endtask

  task automatic test_inject();
    run_inject("f_err", 4, 1'b1, 1'b0, 16'h0AB5);
    run_inject("seq_err", 2, 1'b0, 1'b1, 16'hFAB4);
    run_inject("both", 6, 1'b1, 1'b1, 16'h0AB7);
  endtask

  task automatic test_async_reset();
    do_reset();
    enable = 1'b1;
    step();
    step();
    checks++;
    if (data_bus !== 16'hFAB1 || valid !== 1'b1) begin
      errors++; $display("FAIL ar_pre got %h/%b exp FAB1/1", data_bus, valid);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || data_bus !== 16'h0000) begin
      errors++; $display("FAIL ar_async got %h/%b exp 0000/0", data_bus, valid);
    end
    @(negedge clk);
    reset = 1'b1;
    ready = 1'b1;
    step();
    checks++;
    if (data_bus !== 16'hFAB1 || sent_count !== 8'd0) begin
      errors++; $display("FAIL ar_first got %h/%0d exp FAB1/0", data_bus, sent_count);
    end
    step();
    checks++;
    if (data_bus !== 16'hFAB2 || sent_count !== 8'd1) begin
      errors++; $display("FAIL ar_second got %h/%0d exp FAB2/1", data_bus, sent_count);
    end
  endtask

  initial begin
    test_reset();
    test_stream_and_wrap();
    test_backpressure();
    test_drain();
    test_inject();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
